// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter merging ALU results and FIFO-buffered load returns onto the register-file write port
// Ports: clk, rst_n (sync, active-low); alu_valid/alu_addr/alu_data in; mem_valid/mem_addr/mem_data in, mem_ready out;
//        C/Caddr/Load registered write port out; pending = mask of registers targeted by live queued loads.
module wb_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    output logic [DW-1:0]   C,
    output logic [AW-1:0]   Caddr,
    output logic            Load,
    output logic [2**AW-1:0] pending
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] kill_q, vld;
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic empty, full, pop, push, sel_v;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_d;
    assign empty     = cnt == '0;
    assign full      = cnt == (PW+1)'(DEPTH);
    assign mem_ready = rst_n && !full;
    assign pop       = !alu_valid && !empty;
    // bypassed returns (empty FIFO, no ALU) go straight to the output and are never enqueued
    assign push      = mem_valid && mem_ready && (alu_valid || !empty);
    assign sel_v     = alu_valid || (pop ? !kill_q[rp] : mem_valid);
    assign sel_a     = alu_valid ? alu_addr : pop ? addr_q[rp] : mem_addr;
    assign sel_d     = alu_valid ? alu_data : pop ? data_q[rp] : mem_data;
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // slot i is occupied when its distance from the read pointer is below the count
            vld[i] = {1'b0, PW'(i - int'(rp))} < cnt;
            if (rst_n && vld[i] && !kill_q[i]) pending[addr_q[i]] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            C      <= '0;
            Caddr  <= '0;
            Load   <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            kill_q <= '0;
        end else begin
            Load <= sel_v && sel_a != '0;
            if (sel_v) begin
                C     <= sel_d;
                Caddr <= sel_a;
            end
            for (int i = 0; i < DEPTH; i++)
                if (alu_valid && vld[i] && addr_q[i] == alu_addr) kill_q[i] <= 1'b1;
            // the pushed slot is never occupied, so clearing its kill flag cannot undo a kill above
            if (push) begin
                addr_q[wp] <= mem_addr;
                data_q[wp] <= mem_data;
                kill_q[wp] <= 1'b0;
                wp         <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven directed bench for wb_arbiter
module tb_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, alu_valid, mem_valid, mem_ready, Load;
    logic [3:0] alu_addr, mem_addr, Caddr;
    logic [15:0] alu_data, mem_data, C, pending;
    wb_arbiter #(.DW(16), .AW(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .C(C), .Caddr(Caddr), .Load(Load), .pending(pending)
    );
    typedef struct {
        bit r, av;
        logic [3:0] aa;
        logic [15:0] ad;
        bit mv;
        logic [3:0] ma;
        logic [15:0] md;
        bit l;
        logic [3:0] ca;
        logic [15:0] c, p;
        bit rdy;
    } vec_t;
    vec_t vq[$];
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask
    function automatic void v(bit r, bit av, logic [3:0] aa, logic [15:0] ad, bit mv, logic [3:0] ma,
                              logic [15:0] md, bit l, logic [3:0] ca, logic [15:0] c, logic [15:0] p, bit rdy);
        vec_t t;
        t.r = r; t.av = av; t.aa = aa; t.ad = ad; t.mv = mv; t.ma = ma; t.md = md;
        t.l = l; t.ca = ca; t.c = c; t.p = p; t.rdy = rdy;
        vq.push_back(t);
    endfunction
    task automatic drive(input bit r, input bit av, input logic [3:0] aa, input logic [15:0] ad,
                         input bit mv, input logic [3:0] ma, input logic [15:0] md);
        rst_n = r; alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        //  r av aa  ad        mv ma  md         L  Ca  C          pending    rdy
        v(0, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 0,  16'h0000,  16'h0000,  0);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 0,  16'h0000,  16'h0000,  1);
        v(1, 1, 3,  16'h1234, 0, 0,  16'h0000,  1, 3,  16'h1234,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 3,  16'h1234,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 1, 5,  16'hBEEF,  1, 5,  16'hBEEF,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 5,  16'hBEEF,  16'h0000,  1);
        v(1, 1, 10, 16'h0A01, 1, 6,  16'h0606,  1, 10, 16'h0A01,  16'h0040,  1);
        v(1, 1, 10, 16'h0A02, 1, 7,  16'h0707,  1, 10, 16'h0A02,  16'h00C0,  1);
        v(1, 1, 10, 16'h0A03, 1, 8,  16'h0808,  1, 10, 16'h0A03,  16'h01C0,  1);
        v(1, 1, 10, 16'h0A04, 1, 9,  16'h0909,  1, 10, 16'h0A04,  16'h03C0,  0);
        v(1, 1, 10, 16'h0A05, 0, 0,  16'h0000,  1, 10, 16'h0A05,  16'h03C0,  0);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 6,  16'h0606,  16'h0380,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 7,  16'h0707,  16'h0300,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 8,  16'h0808,  16'h0200,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 9,  16'h0909,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 9,  16'h0909,  16'h0000,  1);
        v(1, 1, 11, 16'h0B01, 1, 7,  16'h7777,  1, 11, 16'h0B01,  16'h0080,  1);
        v(1, 1, 7,  16'h00AA, 0, 0,  16'h0000,  1, 7,  16'h00AA,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 7,  16'h00AA,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 7,  16'h00AA,  16'h0000,  1);
        v(1, 1, 12, 16'h0C01, 1, 12, 16'h0C0C,  1, 12, 16'h0C01,  16'h1000,  1);
        v(1, 1, 12, 16'h0C02, 1, 13, 16'h0D0D,  1, 12, 16'h0C02,  16'h2000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 12, 16'h0C02,  16'h2000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 13, 16'h0D0D,  16'h0000,  1);
        v(1, 1, 14, 16'h0E01, 1, 14, 16'h0E0E,  1, 14, 16'h0E01,  16'h4000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 14, 16'h0E0E,  16'h0000,  1);
        v(1, 1, 15, 16'h0F01, 1, 1,  16'h1111,  1, 15, 16'h0F01,  16'h0002,  1);
        v(1, 0, 0,  16'h0000, 1, 2,  16'h2222,  1, 1,  16'h1111,  16'h0004,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  1, 2,  16'h2222,  16'h0000,  1);
        v(1, 1, 0,  16'hFFFF, 0, 0,  16'h0000,  0, 0,  16'hFFFF,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 1, 0,  16'h5555,  0, 0,  16'h5555,  16'h0000,  1);
        v(1, 0, 0,  16'h0000, 0, 0,  16'h0000,  0, 0,  16'h5555,  16'h0000,  1);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].r, vq[i].av, vq[i].aa, vq[i].ad, vq[i].mv, vq[i].ma, vq[i].md);
            @(posedge clk);
            #1;
            chk("Load", i, 32'(Load), 32'(vq[i].l));
            chk("Caddr", i, 32'(Caddr), 32'(vq[i].ca));
            chk("C", i, 32'(C), 32'(vq[i].c));
            chk("pending", i, 32'(pending), 32'(vq[i].p));
            chk("mem_ready", i, 32'(mem_ready), 32'(vq[i].rdy));
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 10, 16'h0A00 + 16'(k), 1, 4'(3 + k), 16'h3000 + 16'(k));
            @(posedge clk);
            #1;
        end
        chk("rst_fill_pending", 0, 32'(pending), 32'h0038);
        chk("rst_fill_ready", 0, 32'(mem_ready), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_ready_low", 0, 32'(mem_ready), 32'h0);
        chk("rst_pending_low", 0, 32'(pending), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_Load", 0, 32'(Load), 32'h0);
        chk("rst_Caddr", 0, 32'(Caddr), 32'h0);
        chk("rst_C", 0, 32'(C), 32'h0);
        chk("rst_pending", 0, 32'(pending), 32'h0);
        chk("rst_ready", 0, 32'(mem_ready), 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_ready", 0, 32'(mem_ready), 32'h1);
        chk("post_rst_pending", 0, 32'(pending), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_write", k, 32'(Load), 32'h0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
